regfile_cmd_seq: RTL and testbench

- Initiator side of the 8x16 register-file write/read port; drives `data_in`, `writenum`, `write` and `readnum`, and consumes `data_out`.
- Accepts one register-transfer command at a time over a valid/ready handshake and sequences it as 1–8 regfile cycles.
- Supported commands: load-immediate, move, swap, clear-all.
- Sits between the datapath controller and the regfile.

---
 rtl/regfile_pkg.sv | 38 +++
 rtl/regfile.sv | 41 ++++
 rtl/regfile_cmd_seq.sv | 173 +++++++++++++++++
 tb/tb_regfile_cmd_seq.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the 8x16 register file and its command sequencer:
// width constants, the command opcode and sequencer state enums, and the
// command record used by anything that builds or inspects commands.
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 3;
  localparam int NREGS      = 2 ** ADDR_WIDTH;

  // Encoding matches the cmd_op bus of the sequencer.
  typedef enum logic [1:0] {
    OP_LOADI = 2'b00,
    OP_MOVE  = 2'b01,
    OP_SWAP  = 2'b10,
    OP_CLEAR = 2'b11
  } rf_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_MOVE   = 3'd2,
    ST_SWAP_A = 3'd3,
    ST_SWAP_B = 3'd4,
    ST_SWAP_C = 3'd5,
    ST_CLEAR  = 3'd6
  } seq_state_t;

  typedef struct packed {
    rf_op_t                  op;
    logic [ADDR_WIDTH-1:0]   rd;
    logic [ADDR_WIDTH-1:0]   rs;
    logic [DATA_WIDTH-1:0]   imm;
  } rf_cmd_t;

endpackage

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
// NREGS x DATA_WIDTH register file with one synchronous write port and one
// combinational read port. A read of the register being written in the same
// cycle returns the old value (the write lands on the clock edge).
//
// Ports:
//   clk       rising-edge clock
//   data_in   write data
//   writenum  write index
//   write     write enable
//   readnum   read index
//   data_out  R[readnum], combinational
// -----------------------------------------------------------------------------
module regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] writenum,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] readnum,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];

  // NOTE: storage arrays carry no reset; contents survive rst_n and are only
  // ever changed by explicit writes (CLEAR is the architectural way to zero them).
  always_ff @(posedge clk) begin
    if (write) begin
      regs[writenum] <= data_in;
    end
  end

  assign data_out = regs[readnum];

endmodule

// File: rtl/regfile_cmd_seq.sv
// -----------------------------------------------------------------------------
// regfile_cmd_seq
// Initiator for the register-file write/read port. Accepts one command at a
// time over valid/ready and sequences it as a short run of regfile cycles:
//   LOADI : 1 cycle   R[rd] <= imm
//   MOVE  : 1 cycle   R[rd] <= R[rs]
//   SWAP  : 3 cycles  tmp <= R[rs]; R[rs] <= R[rd]; R[rd] <= tmp
//   CLEAR : 8 cycles  R[0..7] <= 0
// done pulses in the first IDLE cycle after the last write has committed;
// cmd_ready is high in that same cycle so commands can run back to back.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cmd_valid/ready command handshake (ready only in IDLE)
//   cmd_op/rd/rs/imm command fields, latched on the accepting edge
//   done            one-cycle completion pulse
//   rf_data_in, rf_writenum, rf_write, rf_readnum  to the regfile
//   rf_data_out     from the regfile (combinational read data)
// -----------------------------------------------------------------------------
module regfile_cmd_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_rd,
  input  logic [ADDR_WIDTH-1:0] cmd_rs,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rf_data_in,
  output logic [ADDR_WIDTH-1:0] rf_writenum,
  output logic                  rf_write,
  output logic [ADDR_WIDTH-1:0] rf_readnum,
  input  logic [DATA_WIDTH-1:0] rf_data_out
);

  import regfile_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  seq_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] rs_q, rs_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [DATA_WIDTH-1:0] tmp_q, tmp_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      rs_q    <= '0;
      imm_q   <= '0;
      tmp_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      imm_q   <= imm_d;
      tmp_q   <= tmp_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = done_q;

  // Read index depends on state only. Kept in its own process because
  // rf_data_out comes back from the regfile as a function of rf_readnum and
  // feeds the write-data mux below.
  always_comb begin
    rf_readnum = '0;
    unique case (state_q)
      ST_MOVE, ST_SWAP_A: rf_readnum = rs_q;
      ST_SWAP_B:          rf_readnum = rd_q;
      default:            rf_readnum = '0;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    imm_d       = imm_q;
    tmp_d       = tmp_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    rf_write    = 1'b0;
    rf_writenum = '0;
    rf_data_in  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          rd_d  = cmd_rd;
          rs_d  = cmd_rs;
          imm_d = cmd_imm;
          unique case (rf_op_t'(cmd_op))
            OP_LOADI: state_d = ST_LOAD;
            OP_MOVE:  state_d = ST_MOVE;
            OP_SWAP:  state_d = ST_SWAP_A;
            OP_CLEAR: state_d = ST_CLEAR;
            default:  state_d = ST_IDLE;
          endcase
        end
      end

      ST_LOAD: begin
        rf_write    = 1'b1;
        rf_writenum = rd_q;
        rf_data_in  = imm_q;
        done_d      = 1'b1;
        state_d     = ST_IDLE;
      end

      ST_MOVE: begin
        rf_write    = 1'b1;
        rf_writenum = rd_q;
        rf_data_in  = rf_data_out;
        done_d      = 1'b1;
        state_d     = ST_IDLE;
      end

      // Park R[rs] in tmp before it is overwritten in SWAP_B.
      ST_SWAP_A: begin
        tmp_d   = rf_data_out;
        state_d = ST_SWAP_B;
      end

      ST_SWAP_B: begin
        rf_write    = 1'b1;
        rf_writenum = rs_q;
        rf_data_in  = rf_data_out;
        state_d     = ST_SWAP_C;
      end

      ST_SWAP_C: begin
        rf_write    = 1'b1;
        rf_writenum = rd_q;
        rf_data_in  = tmp_q;
        done_d      = 1'b1;
        state_d     = ST_IDLE;
      end

      // Counter walks every register index and wraps back to 0 on the last,
      // leaving it ready for the next CLEAR without an explicit reload.
      ST_CLEAR: begin
        rf_write    = 1'b1;
        rf_writenum = cnt_q;
        cnt_d       = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_regfile_cmd_seq
// Drives regfile_cmd_seq attached to the regfile and compares register
// contents, latencies and port activity against a command-level model.
// -----------------------------------------------------------------------------
module tb_regfile_cmd_seq;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_rd;
  logic [2:0]  cmd_rs;
  logic [15:0] cmd_imm;
  logic        done;
  logic [15:0] rf_data_in;
  logic [2:0]  rf_writenum;
  logic        rf_write;
  logic [2:0]  rf_readnum;
  logic [15:0] rf_data_out;

  int checks   = 0;
  int failures = 0;

  // Command-level model of the register file contents.
  logic [15:0] ref_r [8];

  // Observations gathered by run_cmd for the most recent command.
  int          wr_cnt;
  logic [2:0]  wr_num [16];
  logic [15:0] wr_dat [16];
  int          busy_cnt;
  logic [2:0]  first_readnum;
  logic        ready_at_done;

  regfile_cmd_seq #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs     (cmd_rs),
    .cmd_imm    (cmd_imm),
    .done       (done),
    .rf_data_in (rf_data_in),
    .rf_writenum(rf_writenum),
    .rf_write   (rf_write),
    .rf_readnum (rf_readnum),
    .rf_data_out(rf_data_out)
  );

  regfile #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) u_rf (
    .clk     (clk),
    .data_in (rf_data_in),
    .writenum(rf_writenum),
    .write   (rf_write),
    .readnum (rf_readnum),
    .data_out(rf_data_out)
  );

  always #5 clk = ~clk;

  // Cycles from the accepting cycle to the done cycle.
  function automatic int exp_latency(input logic [1:0] op);
    case (rf_op_t'(op))
      OP_LOADI: return 2;
      OP_MOVE:  return 2;
      OP_SWAP:  return 4;
      default:  return 9;
    endcase
  endfunction

  function automatic void model_apply(input logic [1:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [15:0] imm);
    logic [15:0] t;
    case (rf_op_t'(op))
      OP_LOADI: ref_r[rd] = imm;
      OP_MOVE:  ref_r[rd] = ref_r[rs];
      OP_SWAP: begin
        t         = ref_r[rd];
        ref_r[rd] = ref_r[rs];
        ref_r[rs] = t;
      end
      default: for (int i = 0; i < 8; i++) ref_r[i] = 16'h0000;
    endcase
  endfunction

  // Issue one command and follow it to done. lat = -1 if it never completes.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [15:0] imm, output int lat);
    int guard;
    lat           = -1;
    wr_cnt        = 0;
    busy_cnt      = 0;
    ready_at_done = 1'b0;
    first_readnum = '0;
    @(negedge clk);
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs    = rs;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    guard     = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Fields must have been latched; scramble them to prove it.
    cmd_valid     = 1'b0;
    cmd_op        = 2'($urandom);
    cmd_rd        = 3'($urandom);
    cmd_rs        = 3'($urandom);
    cmd_imm       = 16'($urandom);
    first_readnum = rf_readnum;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        lat           = c;
        ready_at_done = cmd_ready;
        break;
      end
      if (!cmd_ready) busy_cnt++;
      if (rf_write && wr_cnt < 16) begin
        wr_num[wr_cnt] = rf_writenum;
        wr_dat[wr_cnt] = rf_data_in;
        wr_cnt++;
      end
      @(negedge clk);
    end
    if (lat > 0) model_apply(op, rd, rs, imm);
  endtask

  task automatic test_reset();
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_rd    = '0;
    cmd_rs    = '0;
    cmd_imm   = '0;
    rst_n     = 1'b0;
    #12;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++;
    if (rf_write !== 1'b0) begin failures++; $display("FAIL reset_write got=%b want=0", rf_write); end
    checks++;
    if (rf_writenum !== 3'd0 || rf_readnum !== 3'd0 || rf_data_in !== 16'h0) begin
      failures++;
      $display("FAIL reset_rf_bus got wn=%0d rn=%0d din=%h want 0/0/0", rf_writenum, rf_readnum, rf_data_in);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_loadi();
    int lat;
    for (int i = 0; i < 8; i++) run_cmd(OP_LOADI, 3'(i), 3'($urandom), 16'($urandom), lat);
    run_cmd(OP_LOADI, 3'd2, 3'd5, 16'h000A, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL loadi_latency got=%0d want=2", lat); end
    checks++;
    if (busy_cnt !== 1) begin failures++; $display("FAIL loadi_busy got=%0d want=1", busy_cnt); end
    checks++;
    if (ready_at_done !== 1'b1) begin failures++; $display("FAIL loadi_ready_at_done got=%b want=1", ready_at_done); end
    checks++;
    if (wr_cnt !== 1 || wr_num[0] !== 3'd2 || wr_dat[0] !== 16'h000A) begin
      failures++;
      $display("FAIL loadi_write got n=%0d wn=%0d din=%h want 1/2/000a", wr_cnt, wr_num[0], wr_dat[0]);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (u_rf.regs[i] !== ref_r[i]) begin
        failures++;
        $display("FAIL loadi_R%0d got=%h want=%h", i, u_rf.regs[i], ref_r[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b want=0", done); end
  endtask

  task automatic test_move();
    int lat;
    run_cmd(OP_LOADI, 3'd7, 3'd0, 16'h0014, lat);
    run_cmd(OP_MOVE, 3'd3, 3'd7, 16'hDEAD, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL move_latency got=%0d want=2", lat); end
    checks++;
    if (first_readnum !== 3'd7) begin failures++; $display("FAIL move_readnum got=%0d want=7", first_readnum); end
    run_cmd(OP_MOVE, 3'd4, 3'd4, 16'h0, lat);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (u_rf.regs[i] !== ref_r[i]) begin
        failures++;
        $display("FAIL move_R%0d got=%h want=%h", i, u_rf.regs[i], ref_r[i]);
      end
    end
  endtask

  task automatic test_swap();
    int lat;
    run_cmd(OP_LOADI, 3'd2, 3'd0, 16'h0001, lat);
    run_cmd(OP_LOADI, 3'd7, 3'd0, 16'h0014, lat);
    run_cmd(OP_SWAP, 3'd2, 3'd7, 16'h0, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL swap_latency got=%0d want=4", lat); end
    checks++;
    if (busy_cnt !== 3) begin failures++; $display("FAIL swap_busy got=%0d want=3", busy_cnt); end
    checks++;
    if (u_rf.regs[2] !== 16'h0014 || u_rf.regs[7] !== 16'h0001) begin
      failures++;
      $display("FAIL swap_2_7 got R2=%h R7=%h want 0014/0001", u_rf.regs[2], u_rf.regs[7]);
    end
    run_cmd(OP_SWAP, 3'd5, 3'd5, 16'h0, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL swap_same_latency got=%0d want=4", lat); end
    run_cmd(OP_SWAP, 3'd0, 3'd7, 16'h0, lat);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (u_rf.regs[i] !== ref_r[i]) begin
        failures++;
        $display("FAIL swap_R%0d got=%h want=%h", i, u_rf.regs[i], ref_r[i]);
      end
    end
  endtask

  task automatic test_clear();
    int lat;
    for (int i = 0; i < 8; i++) run_cmd(OP_LOADI, 3'(i), 3'd0, 16'(i + 1), lat);
    run_cmd(OP_CLEAR, 3'($urandom), 3'($urandom), 16'($urandom), lat);
    checks++;
    if (lat !== 9) begin failures++; $display("FAIL clear_latency got=%0d want=9", lat); end
    checks++;
    if (wr_cnt !== 8) begin failures++; $display("FAIL clear_write_cycles got=%0d want=8", wr_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_num[i] !== 3'(i) || wr_dat[i] !== 16'h0) begin
        failures++;
        $display("FAIL clear_write%0d got wn=%0d din=%h want %0d/0000", i, wr_num[i], wr_dat[i], i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (u_rf.regs[i] !== ref_r[i]) begin
        failures++;
        $display("FAIL clear_R%0d got=%h want=%h", i, u_rf.regs[i], ref_r[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    int   lat2;
    int   guard;
    logic rdy;
    run_cmd(OP_LOADI, 3'd1, 3'd0, 16'h1111, lat);
    run_cmd(OP_LOADI, 3'd4, 3'd0, 16'h4444, lat);
    lat = -1;
    rdy = 1'b0;
    @(negedge clk);
    cmd_op    = OP_SWAP;
    cmd_rd    = 3'd1;
    cmd_rs    = 3'd4;
    cmd_imm   = 16'h0;
    cmd_valid = 1'b1;
    guard     = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    // Keep valid high with other commands while busy; they must be ignored.
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        lat     = c;
        rdy     = cmd_ready;
        cmd_op  = OP_LOADI;
        cmd_rd  = 3'd0;
        cmd_rs  = 3'd3;
        cmd_imm = 16'hBEEF;
        break;
      end
      cmd_op  = 2'($urandom);
      cmd_rd  = 3'($urandom);
      cmd_rs  = 3'($urandom);
      cmd_imm = 16'($urandom);
      @(negedge clk);
    end
    if (lat > 0) model_apply(OP_SWAP, 3'd1, 3'd4, 16'h0);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL b2b_swap_latency got=%0d want=4", lat); end
    checks++;
    if (rdy !== 1'b1) begin failures++; $display("FAIL b2b_ready_in_done got=%b want=1", rdy); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept_in_done got_ready=%b want=0", cmd_ready); end
    lat2 = -1;
    for (int c = 1; c <= 10; c++) begin
      if (done) begin lat2 = c; break; end
      @(negedge clk);
    end
    if (lat2 > 0) model_apply(OP_LOADI, 3'd0, 3'd3, 16'hBEEF);
    checks++;
    if (lat2 !== 2) begin failures++; $display("FAIL b2b_second_latency got=%0d want=2", lat2); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (u_rf.regs[i] !== ref_r[i]) begin
        failures++;
        $display("FAIL b2b_R%0d got=%h want=%h", i, u_rf.regs[i], ref_r[i]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int   lat;
    int   guard;
    logic done_seen;
    for (int i = 0; i < 8; i++) run_cmd(OP_LOADI, 3'(i), 3'd0, 16'h0100 + 16'(i), lat);
    @(negedge clk);
    cmd_op    = OP_CLEAR;
    cmd_valid = 1'b1;
    guard     = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    // Now in the first clear cycle (index 0); advance to index 4, after
    // R0..R3 have been committed.
    repeat (4) @(negedge clk);
    checks++;
    if (rf_write !== 1'b1 || rf_writenum !== 3'd4) begin
      failures++;
      $display("FAIL midclear_position got we=%b wn=%0d want 1/4", rf_write, rf_writenum);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rf_write !== 1'b0) begin failures++; $display("FAIL midclear_write_drop got=%b want=0", rf_write); end
    for (int i = 0; i < 4; i++) ref_r[i] = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (done) done_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (done_seen !== 1'b0) begin failures++; $display("FAIL midclear_no_done got=%b want=0", done_seen); end
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL midclear_ready got=%b want=1", cmd_ready); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (u_rf.regs[i] !== ref_r[i]) begin
        failures++;
        $display("FAIL midclear_R%0d got=%h want=%h", i, u_rf.regs[i], ref_r[i]);
      end
    end
  endtask

  task automatic test_random();
    int          lat;
    logic [1:0]  op;
    for (int n = 0; n < 30; n++) begin
      // Weight CLEAR down so the register contents stay interesting.
      op = ($urandom_range(0, 9) == 0) ? OP_CLEAR : 2'($urandom_range(0, 2));
      run_cmd(op, 3'($urandom), 3'($urandom), 16'($urandom), lat);
      checks++;
      if (lat !== exp_latency(op)) begin
        failures++;
        $display("FAIL rand%0d_latency op=%0d got=%0d want=%0d", n, op, lat, exp_latency(op));
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (u_rf.regs[i] !== ref_r[i]) begin
          failures++;
          $display("FAIL rand%0d_R%0d got=%h want=%h", n, i, u_rf.regs[i], ref_r[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_loadi();
    test_move();
    test_swap();
    test_clear();
    test_back_to_back();
    test_reset_mid_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
